// File: rtl/down_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : down_pkg                                                |
// | Description: FSM state encoding shared by the down-count arbiter.    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package down_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/down_count_arbiter_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : down_cnt_core                                           |
// | Description: Loadable synchronous down counter with clear and zero   |
// |              flag; saturates at zero.                                |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module down_cnt_core #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear wins over load, load wins over decrement; decrement never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = d;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q    = cnt_q;
  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/down_count_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : down_count_arbiter                                      |
// | Description: Round-robin arbiter sharing one down counter among      |
// |              NREQ requesters; pulses done to the owner at zero.      |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module down_count_arbiter
  import down_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] load_val,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      count_out
);

  localparam int              IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;

  logic              pick_found;
  logic [IDXW-1:0]   pick_idx;
  int                cand;
  logic [IDXW-1:0]   next_ptr;
  logic [WIDTH-1:0]  load_sel;
  logic [WIDTH-1:0]  load_arr [NREQ];

  logic              cnt_load;
  logic              cnt_clr;
  logic              cnt_en;
  logic [WIDTH-1:0]  cnt_q;
  logic              cnt_zero;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign load_arr[gi] = load_val[gi*WIDTH +: WIDTH];
  end

  // Scan upward from the round-robin pointer, wrapping; first set request wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand = (int'(rr_ptr_q) + off) % NREQ;
      if (!pick_found && req[IDXW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDXW'(cand);
      end
    end
  end

  assign load_sel = load_arr[pick_idx];
  assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          cnt_load          = 1'b1;
          state_d           = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          grant_d  = '0;
          cnt_clr  = 1'b1;
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        grant_d  = '0;
        rr_ptr_d = next_ptr;
        state_d  = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  down_cnt_core #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .d     (load_sel),
    .q     (cnt_q),
    .zero  (cnt_zero)
  );

  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE) ? grant_q : '0;
  assign count_out = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_down_count_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_down_count_arbiter                                   |
// | Description: Scoreboard bench for down_count_arbiter against a       |
// |              grant-time / elapsed-cycle reference model.             |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_down_count_arbiter;

  localparam int WIDTH = 2;
  localparam int NREQ  = 2;
  localparam int LW    = NREQ * WIDTH;
  localparam int NCYC  = 3000;

  logic             clk = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic [LW-1:0]    load_val;
  logic             abort;
  logic [NREQ-1:0]  grant;
  logic             busy;
  logic [NREQ-1:0]  done;
  logic [WIDTH-1:0] count_out;

  typedef struct packed {
    logic [NREQ-1:0]  grant;
    logic             busy;
    logic [NREQ-1:0]  done;
    logic [WIDTH-1:0] cnt;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_e;
  int    tests = 0;
  int    fails = 0;

  // Reference model: owner index (-1 when free), start value, edges since grant.
  int m_owner = -1;
  int m_rr    = 0;
  int m_v     = 0;
  int m_k     = 0;
  int rst_cnt = 0;

  down_count_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .load_val  (load_val),
    .abort     (abort),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .count_out (count_out)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic rst_l, input logic [NREQ-1:0] r,
                            input logic [LW-1:0] lv, input logic ab);
    bit found;
    int w;
    if (!rst_l) begin
      m_owner = -1;
      m_rr    = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int off = 0; off < NREQ; off++) begin
        w = (m_rr + off) % NREQ;
        if (!found && r[w]) begin
          found   = 1;
          m_owner = w;
          m_v     = int'(lv[w*WIDTH +: WIDTH]);
          m_k     = 0;
        end
      end
    end else if (ab && m_k <= m_v) begin
      m_rr    = (m_owner + 1) % NREQ;
      m_owner = -1;
    end else begin
      m_k = m_k + 1;
      if (m_k == m_v + 2) begin
        m_rr    = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
  endtask

  function automatic snap_t model_out();
    snap_t s;
    s = '0;
    if (m_owner >= 0) begin
      s.grant = {{(NREQ-1){1'b0}}, 1'b1} << m_owner;
      s.busy  = 1'b1;
      s.cnt   = (m_k <= m_v) ? WIDTH'(m_v - m_k) : '0;
      s.done  = (m_k == m_v + 1) ? s.grant : '0;
    end
    return s;
  endfunction

  // Stimulus: model the edge just taken, push the expectation, drive next inputs.
  initial begin
    reset    = 1'b0;
    req      = '0;
    load_val = '0;
    abort    = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      model_step(reset, req, load_val, abort);
      if (cyc == 19) begin
        reset = 1'b1;
      end else if (cyc > 80 && reset && m_owner >= 0 && $urandom_range(0, 99) < 2) begin
        reset   = 1'b0;
        m_owner = -1;
        m_rr    = 0;
        rst_cnt = 2;
      end else if (cyc > 19 && !reset) begin
        if (rst_cnt == 0) reset = 1'b1;
        else rst_cnt = rst_cnt - 1;
      end
      exp_q.push_back(model_out());
      abort = 1'b0;
      if (cyc < 19) begin
        req = '0;
      end else if (cyc < 30) begin
        req      = 2'b01;
        load_val = {2'd0, 2'd3};
      end else if (cyc < 50) begin
        req      = 2'b11;
        load_val = {2'd1, 2'd2};
      end else if (cyc < 60) begin
        req      = 2'b10;
        load_val = {2'd0, 2'd0};
      end else if (cyc < 80) begin
        req      = 2'b11;
        load_val = {2'd1, 2'd3};
        abort    = (m_owner == 0 && m_k <= m_v && (m_v - m_k) == 2);
      end else begin
        req      = NREQ'($urandom);
        load_val = LW'($urandom);
        abort    = ($urandom_range(0, 7) == 0);
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    tests = tests + 1;
    if (exp_q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: every cycle the DUT presents its outputs, compare with the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        tests = tests + 1;
        if (grant !== mon_e.grant || busy !== mon_e.busy ||
            done !== mon_e.done || count_out !== mon_e.cnt) begin
          fails = fails + 1;
          $display("FAIL outputs t=%0t: got grant=%b busy=%b done=%b count=%0d, required grant=%b busy=%b done=%b count=%0d",
                   $time, grant, busy, done, count_out,
                   mon_e.grant, mon_e.busy, mon_e.done, mon_e.cnt);
        end
      end
    end
  end

endmodule
`default_nettype wire
